etapa_wb_banco: RTL and testbench
=================================

// Module: etapa_wb_banco
// PURPOSE
// Write-back stage plus register bank. Sits directly downstream of the MEM/WB control register:
// consumes MemaReg/EscrReg (already registered on clk) together with the MEM/WB data
// register outputs, which are aligned to the same cycle.
// Selects the write-back value, writes the register bank and serves the two ID-stage read ports
// with write-before-read bypass. Also exports a one-cycle-delayed write record for the EX
// forwarding unit and a write counter for debug.
// PARAMETERS
// DATA_W  32  register/data width
// ADDR_W  5   register index width; bank depth = 2**ADDR_W
// CNT_W   16  width of write counter cnt_escr
// PORTS
// clk         in   1       rising-edge clock
// reset       in   1       synchronous, active-high reset
// MemaReg     in   1       1: write-back from DatoMem, 0: from ResALU
// EscrReg     in   1       register write request
// DatoMem     in   DATA_W  data memory read value (MEM/WB register)
// ResALU      in   DATA_W  ALU result (MEM/WB register)
// RegDestino  in   ADDR_W  destination register index
// LeerReg1    in   ADDR_W  read port 1 index (ID stage)
// LeerReg2    in   ADDR_W  read port 2 index (ID stage)
// Dato1       out  DATA_W  read port 1 data (combinational)
// Dato2       out  DATA_W  read port 2 data (combinational)
// wb_dato     out  DATA_W  current write-back value (combinational)
// fwd_esc     out  1       registered: a bank write took effect last cycle
// fwd_rd      out  ADDR_W  registered: index of that write
// fwd_dato    out  DATA_W  registered: value of that write
// cnt_escr    out  CNT_W   number of effective writes since reset
// BEHAVIOUR
// - wb_dato = MemaReg ? DatoMem : ResALU; pure mux, zero latency.
// - wr_ef = EscrReg & (RegDestino != 0) & ~reset. Register 0 is never written and always reads 0.
// - Bank write: at posedge clk, if reset, every entry <= 0; else if wr_ef, bank[RegDestino] <= wb_dato.
//   Written value is visible from stored state on the cycle after the edge.
// - Read port n (n=1,2): LeerRegn==0 -> 0; else if wr_ef & LeerRegn==RegDestino -> wb_dato
//   (same-cycle bypass); else bank[LeerRegn]. Both ports are independent; both may hit the bypass.
// - Reset dominates: a write presented in a reset cycle is dropped, the bypass is off, and reads
//   return stored contents (all 0 from the cycle after the first reset edge).
// - Forward record: at posedge clk, if reset -> fwd_esc<=0, fwd_rd<=0, fwd_dato<=0;
//   else fwd_esc<=wr_ef, fwd_rd<=RegDestino, fwd_dato<=wb_dato.
//   fwd_rd/fwd_dato are meaningful only when fwd_esc=1.
// - cnt_escr: reset -> 0; increments by 1 on each wr_ef cycle; wraps 2**CNT_W-1 -> 0 silently.
// - Attempted writes to register 0 do not set fwd_esc and do not count.
// - No stall input: every asserted EscrReg cycle is one write; back-to-back writes to the same index
//   leave the last one stored.
// - X on inputs while EscrReg=0 must not alter bank, counter or fwd_esc.
// TESTING
// T1 reset 2 cycles, then read all 32 indices -> Dato1/Dato2=0, cnt_escr=0, fwd_esc=0.
// T2 EscrReg=1 MemaReg=0 ResALU=0x0000_00A5 RegDestino=3; LeerReg1=3 same cycle -> Dato1=0xA5
//    (bypass); next cycle Dato1=0xA5 from bank, fwd_esc=1 fwd_rd=3 fwd_dato=0xA5, cnt_escr=1.
// T3 EscrReg=1 MemaReg=1 DatoMem=0xDEAD_BEEF ResALU=0x1 RegDestino=0 -> Dato1(LeerReg1=0)=0
//    always, fwd_esc=0, cnt_escr unchanged.
// T4 write 0x11 to r7, next cycle write 0x22 to r7 with LeerReg1=LeerReg2=7 -> both ports 0x22
//    that cycle and after.
// T5 write 0x55 to r9 with reset=1 in the same cycle -> r9 reads 0, fwd_esc=0, cnt_escr=0.
// T6 CNT_W=4: 17 effective writes -> cnt_escr=1 after the 17th.

Source files
------------

// File: rtl/etapa_wb_banco.sv
// Write-back stage and register bank: selects the write-back value, updates the bank,
// serves two bypassed read ports and exports a delayed write record plus a write counter.
module etapa_wb_banco #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemaReg,
    input  logic              EscrReg,
    input  logic [DATA_W-1:0] DatoMem,
    input  logic [DATA_W-1:0] ResALU,
    input  logic [ADDR_W-1:0] RegDestino,
    input  logic [ADDR_W-1:0] LeerReg1,
    input  logic [ADDR_W-1:0] LeerReg2,
    output logic [DATA_W-1:0] Dato1,
    output logic [DATA_W-1:0] Dato2,
    output logic [DATA_W-1:0] wb_dato,
    output logic              fwd_esc,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_dato,
    output logic [CNT_W-1:0]  cnt_escr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] bank [DEPTH];
    logic              wr_ef;

    assign wb_dato = MemaReg ? DatoMem : ResALU;

    // Reset gates the enable so a write in a reset cycle neither lands nor bypasses.
    assign wr_ef = EscrReg & (RegDestino != '0) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_ef) begin
            bank[RegDestino] <= wb_dato;
        end
    end

    always_comb begin
        Dato1 = bank[LeerReg1];
        if (LeerReg1 == '0) begin
            Dato1 = '0;
        end else if (wr_ef && (LeerReg1 == RegDestino)) begin
            Dato1 = wb_dato;
        end
    end

    always_comb begin
        Dato2 = bank[LeerReg2];
        if (LeerReg2 == '0) begin
            Dato2 = '0;
        end else if (wr_ef && (LeerReg2 == RegDestino)) begin
            Dato2 = wb_dato;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_esc  <= 1'b0;
            fwd_rd   <= '0;
            fwd_dato <= '0;
            cnt_escr <= '0;
        end else begin
            fwd_esc  <= wr_ef;
            fwd_rd   <= RegDestino;
            fwd_dato <= wb_dato;
            if (wr_ef) begin
                cnt_escr <= cnt_escr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_etapa_wb_banco.sv
// Directed bench for etapa_wb_banco: reset state, bypass, r0 protection, reset priority,
// bank read-back and counter wrap on a narrow-counter instance.
module tb_etapa_wb_banco;

    logic        clk;
    logic        reset;
    logic        MemaReg;
    logic        EscrReg;
    logic [31:0] DatoMem;
    logic [31:0] ResALU;
    logic [4:0]  RegDestino;
    logic [4:0]  LeerReg1;
    logic [4:0]  LeerReg2;
    logic [31:0] Dato1, Dato2, wb_dato, fwd_dato;
    logic        fwd_esc;
    logic [4:0]  fwd_rd;
    logic [15:0] cnt_escr;

    logic [31:0] c_dato1, c_dato2, c_wb_dato, c_fwd_dato;
    logic        c_fwd_esc;
    logic [4:0]  c_fwd_rd;
    logic [3:0]  c_cnt_escr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    etapa_wb_banco dut (
        .clk(clk), .reset(reset), .MemaReg(MemaReg), .EscrReg(EscrReg),
        .DatoMem(DatoMem), .ResALU(ResALU), .RegDestino(RegDestino),
        .LeerReg1(LeerReg1), .LeerReg2(LeerReg2), .Dato1(Dato1), .Dato2(Dato2),
        .wb_dato(wb_dato), .fwd_esc(fwd_esc), .fwd_rd(fwd_rd),
        .fwd_dato(fwd_dato), .cnt_escr(cnt_escr)
    );

    etapa_wb_banco #(.CNT_W(4)) dut_cnt4 (
        .clk(clk), .reset(reset), .MemaReg(MemaReg), .EscrReg(EscrReg),
        .DatoMem(DatoMem), .ResALU(ResALU), .RegDestino(RegDestino),
        .LeerReg1(LeerReg1), .LeerReg2(LeerReg2), .Dato1(c_dato1), .Dato2(c_dato2),
        .wb_dato(c_wb_dato), .fwd_esc(c_fwd_esc), .fwd_rd(c_fwd_rd),
        .fwd_dato(c_fwd_dato), .cnt_escr(c_cnt_escr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        EscrReg    = 1'b1;
        MemaReg    = 1'b0;
        ResALU     = val;
        RegDestino = rd;
        tick();
        EscrReg    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; MemaReg = 1'b0; EscrReg = 1'b0;
        DatoMem = '0; ResALU = '0; RegDestino = '0; LeerReg1 = '0; LeerReg2 = '0;
        tick();
        tick();
        reset = 1'b0;

        // T1: bank cleared
        for (int i = 0; i < 32; i++) begin
            LeerReg1 = 5'(i);
            LeerReg2 = 5'(31 - i);
            #1;
            check_val($sformatf("t1_d1_r%0d", i), Dato1, 32'h0);
            check_val($sformatf("t1_d2_r%0d", 31 - i), Dato2, 32'h0);
        end
        check_val("t1_cnt", 32'(cnt_escr), 32'h0);
        check_val("t1_fwd_esc", 32'(fwd_esc), 32'h0);

        // T2: same-cycle bypass then stored value
        EscrReg = 1'b1; MemaReg = 1'b0; ResALU = 32'h0000_00A5; DatoMem = 32'h1234_5678;
        RegDestino = 5'd3; LeerReg1 = 5'd3;
        #1;
        check_val("t2_bypass", Dato1, 32'hA5);
        check_val("t2_wb_alu", wb_dato, 32'hA5);
        tick();
        EscrReg = 1'b0;
        #1;
        check_val("t2_stored", Dato1, 32'hA5);
        check_val("t2_fwd_esc", 32'(fwd_esc), 32'h1);
        check_val("t2_fwd_rd", 32'(fwd_rd), 32'h3);
        check_val("t2_fwd_dato", fwd_dato, 32'hA5);
        check_val("t2_cnt", 32'(cnt_escr), 32'h1);

        // T3: writes to r0 are discarded
        EscrReg = 1'b1; MemaReg = 1'b1; DatoMem = 32'hDEAD_BEEF; ResALU = 32'h1;
        RegDestino = 5'd0; LeerReg1 = 5'd0;
        #1;
        check_val("t3_wb_mem", wb_dato, 32'hDEAD_BEEF);
        check_val("t3_r0_bypass", Dato1, 32'h0);
        tick();
        EscrReg = 1'b0;
        #1;
        check_val("t3_r0_read", Dato1, 32'h0);
        check_val("t3_fwd_esc", 32'(fwd_esc), 32'h0);
        check_val("t3_cnt", 32'(cnt_escr), 32'h1);

        // T4: back-to-back writes to r7, last wins, both ports bypass
        write_reg(5'd7, 32'h11);
        EscrReg = 1'b1; ResALU = 32'h22; RegDestino = 5'd7;
        LeerReg1 = 5'd7; LeerReg2 = 5'd7;
        #1;
        check_val("t4_d1_bypass", Dato1, 32'h22);
        check_val("t4_d2_bypass", Dato2, 32'h22);
        tick();
        EscrReg = 1'b0;
        #1;
        check_val("t4_d1_stored", Dato1, 32'h22);
        check_val("t4_d2_stored", Dato2, 32'h22);
        check_val("t4_cnt", 32'(cnt_escr), 32'h3);

        // T5: reset dominates a simultaneous write
        reset = 1'b1; EscrReg = 1'b1; MemaReg = 1'b0; ResALU = 32'h55;
        RegDestino = 5'd9; LeerReg1 = 5'd9; LeerReg2 = 5'd7;
        #1;
        check_val("t5_no_bypass", Dato1, 32'h0);
        tick();
        reset = 1'b0; EscrReg = 1'b0;
        #1;
        check_val("t5_r9", Dato1, 32'h0);
        check_val("t5_r7_cleared", Dato2, 32'h0);
        check_val("t5_fwd_esc", 32'(fwd_esc), 32'h0);
        check_val("t5_cnt", 32'(cnt_escr), 32'h0);

        // T7: fill r1..r8 from both mux legs, read back from the bank
        for (int i = 1; i <= 8; i++) begin
            EscrReg = 1'b1; RegDestino = 5'(i);
            MemaReg = i[0];
            DatoMem = 32'h0101_0101 * i + 32'hF000_0000;
            ResALU  = 32'h0000_1111 * i;
            exp_q.push_back(i[0] ? (32'h0101_0101 * i + 32'hF000_0000) : (32'h0000_1111 * i));
            tick();
        end
        EscrReg = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            LeerReg2 = 5'(i);
            #1;
            check_val($sformatf("t7_r%0d", i), Dato2, exp_q.pop_front());
        end
        check_val("t7_cnt", 32'(cnt_escr), 32'd8);

        // T6: narrow counter wraps 15 -> 0 -> 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_cnt4_reset", 32'(c_cnt_escr), 32'h0);
        for (int i = 1; i <= 17; i++) begin
            write_reg(5'((i % 31) + 1), 32'(i));
            if (i == 15) check_val("t6_cnt4_15", 32'(c_cnt_escr), 32'd15);
            if (i == 16) check_val("t6_cnt4_wrap", 32'(c_cnt_escr), 32'd0);
        end
        #1;
        check_val("t6_cnt4_17", 32'(c_cnt_escr), 32'd1);
        check_val("t6_cnt16_17", 32'(cnt_escr), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
